// File: rtl/clk_div_ctrl_pkg.sv
// ============================================================================
// Module      : clk_div_ctrl_pkg
// Description : Shared state encoding and defaults for the divider controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_ctrl_pkg;

    localparam logic [7:0] c_DEFAULT_RATIO = 8'd8;
    localparam logic [7:0] c_MAX_RATIO     = 8'd255;
    localparam int         c_SETTLE_CYC    = 4;
    localparam int         c_CNT_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_LOAD  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/clk_div_settle_cnt.sv
// ============================================================================
// Module      : clk_div_settle_cnt
// Description : Loadable down-counter with zero flag, used to time the drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_settle_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Count saturates at zero so a lingering decrement request is harmless.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ============================================================================
// Module      : clk_div_ctrl
// Description : Sequences safe divider ratio changes: drain, load, hold, resume.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int                 RATIO_W       = 8,
    parameter logic [RATIO_W-1:0] DEFAULT_RATIO = RATIO_W'(c_DEFAULT_RATIO),
    parameter logic [RATIO_W-1:0] MAX_RATIO     = RATIO_W'(c_MAX_RATIO),
    parameter int                 SETTLE_CYC    = c_SETTLE_CYC
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_req_valid,
    input  logic [RATIO_W-1:0] i_req_ratio,
    output logic               o_req_ready,
    output logic               o_clk_en,
    output logic [RATIO_W-1:0] o_div_ratio,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [c_CNT_W-1:0] c_SETTLE_LOAD = c_CNT_W'(SETTLE_CYC - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [RATIO_W-1:0]   r_ratio;
    logic                 w_accept;
    logic                 w_legal;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;
    logic                 w_cnt_zero;

    assign w_accept   = i_req_valid & o_req_ready;
    // Widened compare keeps the upper bound meaningful even at MAX_RATIO = all ones.
    assign w_legal    = (i_req_ratio != '0) && ({1'b0, i_req_ratio} <= {1'b0, MAX_RATIO});
    assign w_cnt_load = w_accept & w_legal & (r_state == ST_RUN);
    assign w_cnt_dec  = (r_state == ST_DRAIN);

    clk_div_settle_cnt #(
        .CNT_W      (c_CNT_W)
    ) u_settle_cnt (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (c_SETTLE_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_legal) w_state_nxt = ST_LOAD;
                end else if (i_enable) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_legal) w_state_nxt = ST_DRAIN;
                end else if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_cnt_zero) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_state_nxt = i_enable ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ratio     <= DEFAULT_RATIO;
            o_div_ratio <= DEFAULT_RATIO;
            o_clk_en    <= 1'b0;
            o_req_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            o_clk_en    <= (w_state_nxt == ST_RUN);
            o_req_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN);
            o_busy      <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_LOAD) ||
                           (w_state_nxt == ST_HOLD);
            o_done      <= (r_state == ST_HOLD);
            o_err       <= w_accept & ~w_legal;
            if (w_accept && w_legal) begin
                r_ratio <= i_req_ratio;
            end
            if (w_state_nxt == ST_LOAD) begin
                o_div_ratio <= (r_state == ST_IDLE) ? i_req_ratio : r_ratio;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Self-checking bench for clk_div_ctrl with a countdown reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_ctrl;

    localparam int c_SETTLE = 4;
    localparam int c_MAXR   = 100;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_ratio = 8'd0;
    logic       req_ready;
    logic       clk_en;
    logic [7:0] div_ratio;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    clk_div_ctrl #(
        .RATIO_W       (8),
        .DEFAULT_RATIO (8'd8),
        .MAX_RATIO     (8'd100),
        .SETTLE_CYC    (c_SETTLE)
    ) dut (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_req_valid (req_valid),
        .i_req_ratio (req_ratio),
        .o_req_ready (req_ready),
        .o_clk_en    (clk_en),
        .o_div_ratio (div_ratio),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_left counts remaining cycles of an in-flight change
    // (clk_en low); the new ratio appears when two cycles remain.
    int         m_left  = 0;
    bit         m_run   = 1'b0;
    logic [7:0] m_ratio = 8'd8;
    logic [7:0] m_pend  = 8'd8;
    bit         m_done  = 1'b0;
    bit         m_err   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_run = 1'b0; m_ratio = 8'd8; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            m_err  = 1'b0;
            if (m_left > 0) begin
                if (m_left == 1) begin
                    m_done = 1'b1;
                    m_run  = enable;
                end
                m_left--;
                if (m_left == 2) m_ratio = m_pend;
            end else if (req_valid) begin
                if (req_ratio == 8'd0 || int'(req_ratio) > c_MAXR) begin
                    m_err = 1'b1;
                end else begin
                    m_pend = req_ratio;
                    if (m_run) begin
                        m_left = c_SETTLE + 2;
                    end else begin
                        m_left  = 2;
                        m_ratio = req_ratio;
                    end
                end
            end else begin
                m_run = enable;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("clk_en",    32'(clk_en),    32'(m_run && m_left == 0));
            chk("req_ready", 32'(req_ready), 32'(m_left == 0));
            chk("busy",      32'(busy),      32'(m_left > 0));
            chk("div_ratio", 32'(div_ratio), 32'(m_ratio));
            chk("done",      32'(done),      32'(m_done));
            chk("err",       32'(err),       32'(m_err));
        end
    end

    logic       cap_en    [8];
    logic       cap_busy  [8];
    logic       cap_done  [8];
    logic [7:0] cap_ratio [8];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called just after a clock edge; records eight consecutive cycles.
    task automatic capture();
        for (int k = 0; k < 8; k++) begin
            #4;
            cap_en[k]    = clk_en;
            cap_busy[k]  = busy;
            cap_done[k]  = done;
            cap_ratio[k] = div_ratio;
            step();
        end
    endtask

    initial begin
        int lows;
        int busies;
        int dones;

        step();
        chk_on = 1'b1;
        repeat (2) step();
        #4;
        chk("rst_ratio", 32'(div_ratio), 32'd8);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        #4;
        chk("post_rst_ratio", 32'(div_ratio), 32'd8);
        chk("post_rst_clk_en", 32'(clk_en), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        step();

        enable = 1'b1;
        step();
        #4;
        chk("run_clk_en", 32'(clk_en), 32'd1);
        chk("run_ratio", 32'(div_ratio), 32'd8);
        step();

        // Ratio change to 5 while running; later ratio input wiggles are ignored.
        req_valid = 1'b1;
        req_ratio = 8'd5;
        step();
        req_valid = 1'b0;
        req_ratio = 8'd77;
        capture();
        lows = 0; busies = 0;
        for (int k = 0; k < 6; k++) begin
            if (!cap_en[k]) lows++;
            if (cap_busy[k]) busies++;
        end
        chk("chg5_low_cycles", 32'(lows), 32'd6);
        chk("chg5_busy_cycles", 32'(busies), 32'd6);
        chk("chg5_resume_en", 32'(cap_en[6]), 32'd1);
        chk("chg5_done_at_resume", 32'(cap_done[6]), 32'd1);
        chk("chg5_busy_after", 32'(cap_busy[6]), 32'd0);
        chk("chg5_ratio_drain", 32'(cap_ratio[3]), 32'd8);
        chk("chg5_ratio_load", 32'(cap_ratio[4]), 32'd5);
        chk("chg5_ratio_final", 32'(cap_ratio[7]), 32'd5);

        // Illegal ratios 0 and 200 (MAX_RATIO = 100).
        req_valid = 1'b1;
        req_ratio = 8'd0;
        step();
        #4;
        chk("ill0_err", 32'(err), 32'd1);
        chk("ill0_ratio", 32'(div_ratio), 32'd5);
        chk("ill0_clk_en", 32'(clk_en), 32'd1);
        req_ratio = 8'd200;
        step();
        #4;
        chk("ill200_err", 32'(err), 32'd1);
        chk("ill200_ratio", 32'(div_ratio), 32'd5);
        chk("ill200_busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
        step();
        #4;
        chk("ill_err_clear", 32'(err), 32'd0);
        step();

        // Change to 3 coincident with enable falling: ends in IDLE.
        req_valid = 1'b1;
        req_ratio = 8'd3;
        enable    = 1'b0;
        step();
        req_valid = 1'b0;
        capture();
        lows = 0;
        for (int k = 0; k < 8; k++) if (!cap_en[k]) lows++;
        chk("chg3_never_enabled", 32'(lows), 32'd8);
        chk("chg3_done", 32'(cap_done[6]), 32'd1);
        chk("chg3_ratio", 32'(cap_ratio[6]), 32'd3);
        chk("chg3_done_once", 32'(cap_done[7]), 32'd0);

        // Bypass ratio 1 from IDLE goes straight to load.
        req_valid = 1'b1;
        req_ratio = 8'd1;
        step();
        req_valid = 1'b0;
        capture();
        chk("idle1_ratio_load", 32'(cap_ratio[0]), 32'd1);
        chk("idle1_busy_hold", 32'(cap_busy[1]), 32'd1);
        chk("idle1_done", 32'(cap_done[2]), 32'd1);
        chk("idle1_clk_en", 32'(cap_en[2]), 32'd0);

        // Reset in the second drain cycle of a change to 12.
        enable = 1'b1;
        step();
        req_valid = 1'b1;
        req_ratio = 8'd12;
        step();
        req_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #4;
        chk("abort_ratio", 32'(div_ratio), 32'd8);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_clk_en", 32'(clk_en), 32'd0);
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            #4;
            if (done) dones++;
            step();
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_ratio_kept", 32'(div_ratio), 32'd8);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            req_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       req_ratio = 8'd0;
                1:       req_ratio = 8'd1;
                2:       req_ratio = 8'd100;
                3:       req_ratio = 8'd101;
                4:       req_ratio = 8'd255;
                default: req_ratio = 8'($urandom);
            endcase
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        repeat (12) step();
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
